dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
Parametrised successor to the single-word data memory. It is a synchronous-read, byte-addressable RV32 data RAM with:
- a valid/ready request and response handshake, one outstanding access;
- byte/half/word stores via lane enables;
- sign- and zero-extending loads decoded from funct3;
- error reporting for illegal size codes.

It sits between the core's MEM stage and the on-chip data array.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, at least 4
ADDR_W, 32, width of req_addr
AW, $clog2(DEPTH), derived local parameter; word-index width, not overridable

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high with req_valid
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_funct3  in  3  RISC-V size/sign code
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  load result, extended; 0 for stores and errors
rsp_err  out  1  access rejected

Behaviour:
- One clock; reset is synchronous and active-low. On the clk edge with rst_n=0: rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not reset.
- req_ready = !rsp_valid || rsp_ready (combinational). Only one response is ever held.
- Accept = req_valid && req_ready && rst_n. Nothing is written or read when rst_n=0, even if req_valid=1.
- Word index = req_addr[AW+1:2]. Address bits above AW+1 are ignored, so addresses wrap modulo 4*DEPTH bytes. Lane = req_addr[1:0].
- funct3 decode:
  - 000 = byte, signed load / SB
  - 001 = half, signed load / SH
  - 010 = word / SW
  - 100 = byte, unsigned load
  - 101 = half, unsigned load
  - 011, 110, 111 are illegal for both loads and stores.
  - 100 and 101 with req_we=1 are illegal.
- Store on accept: write the byte lanes selected by size and lane in that same edge.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected bytes are unchanged.
- Load on accept: read the word at the accept edge. The response is registered, so latency is 1 cycle: rsp_valid rises on the edge after accept.
  - Select the byte or half by lane, then sign- or zero-extend to 32 bits.
- Every accepted request, load or store, produces exactly one response. For stores: rsp_rdata=0, rsp_err=0.
- Response held stable while rsp_valid && !rsp_ready.
- Back-to-back: if rsp_ready=1 while rsp_valid=1 and a new request is accepted the same cycle, the new response replaces the old one on the next edge (no bubble). If rsp_ready=1 and nothing is accepted, rsp_valid clears on the next edge.
- Load following a store to the same address: the load is accepted at a later edge than the store, so it sees the stored data. No forwarding is needed.
- Illegal funct3: no RAM write; response has rsp_err=1, rsp_rdata=0, latency 1.
- Reset asserted while a response is pending: the response is discarded, rsp_valid=0 after that edge.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=00, is misaligned.
  - Misaligned access: no write, rsp_err=1, rsp_rdata=0, latency 1.
- Not defined: misaligned addresses are silently aligned down (half ignores addr[0], word ignores addr[1:0]). rsp_err reports only illegal funct3.

Test Plan:
- SW 0x8899AABB @0x10, then LW @0x10 -> rsp_valid one cycle after accept, rsp_rdata=0x8899AABB, rsp_err=0.
- Sub-word loads from word 0x8899AABB @0x10:
  - SB 0x5A @0x13, then LW @0x10 -> rsp_rdata=0x5A99AABB.
  - LB @0x11 -> 0xFFFFFFAA.
  - LBU @0x11 -> 0x000000AA.
  - LH @0x12 -> 0x00005A99.
  - LHU @0x10 -> 0x0000AABB.
- rsp_ready held 0 for 3 cycles after a load response -> req_ready=0, rsp_rdata stable. Release -> next request accepted that same cycle, response the cycle after.
- Wrap-around with DEPTH=256: SW 0x12345678 @0x400, then LW @0x000 -> rsp_rdata=0x12345678.
- Illegal funct3 / misaligned access:
  - funct3=011 store @0x20 -> rsp_err=1, word @0x20 unchanged.
  - With DMEM_MISALIGN_TRAP_EN, LW @0x22 -> rsp_err=1, rsp_rdata=0.
  - Without it, LW @0x22 -> word @0x20, rsp_err=0.
- Reset:
  - rst_n=0 for one edge while rsp_valid=1 -> rsp_valid=0, rsp_rdata=0.
  - SW issued during reset -> no write; a later LW shows the old data.

Source files
------------

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32 byte-addressable data RAM with valid/ready load/store port
//
// Optional build macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word -> rsp_err)
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid / req_ready       request handshake (one outstanding access)
//   req_we, req_addr            1 = store / 0 = load, byte address
//   req_funct3, req_wdata       RISC-V size/sign code, right-aligned store data
//   rsp_valid / rsp_ready       response handshake
//   rsp_rdata, rsp_err          extended load data (0 for stores/errors), reject flag

module dmem_lsu #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          accept;

    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          is_unsigned;
    logic          legal;
    logic          misalign;
    logic          bad;

    logic [3:0]    byte_en;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_ext;

    // Address bits above the word index are intentionally ignored so the
    // array aliases modulo 4*DEPTH bytes.
    generate
        if (ADDR_W > AW + 2) begin : g_hi_addr
            logic unused_hi_addr;
            assign unused_hi_addr = ^req_addr[ADDR_W-1:AW+2];
        end
    endgenerate

    assign word_idx  = req_addr[AW+1:2];
    assign lane      = req_addr[1:0];

    // A held response only blocks new requests while it cannot drain.
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready && rst_n;

    // funct3 decode; unsigned variants only exist for loads.
    always_comb begin
        is_byte     = 1'b0;
        is_half     = 1'b0;
        is_word     = 1'b0;
        is_unsigned = 1'b0;
        legal       = 1'b0;
        case (req_funct3)
            3'b000: begin is_byte = 1'b1; legal = 1'b1; end
            3'b001: begin is_half = 1'b1; legal = 1'b1; end
            3'b010: begin is_word = 1'b1; legal = 1'b1; end
            3'b100: begin is_byte = 1'b1; is_unsigned = 1'b1; legal = !req_we; end
            3'b101: begin is_half = 1'b1; is_unsigned = 1'b1; legal = !req_we; end
            default: legal = 1'b0;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = (is_half && lane[0]) || (is_word && (lane != 2'b00));
`else
    // Misaligned halves/words are aligned down by the lane selection below.
    assign misalign = 1'b0;
`endif

    assign bad = !legal || misalign;

    // Store lane enables and data replicated across the lanes it may land on.
    always_comb begin
        byte_en = 4'b0000;
        wr_data = req_wdata;
        if (is_byte) begin
            byte_en = 4'b0001 << lane;
            wr_data = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{req_wdata[15:0]}};
        end else if (is_word) begin
            byte_en = 4'b1111;
            wr_data = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Load path: array word read at the accept edge, lane-selected and
    // extended, then captured in the response register.
    assign rd_word = mem[word_idx];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_ext = 32'd0;
        if (!req_we && !bad) begin
            if (is_byte) begin
                load_ext = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end else if (is_half) begin
                load_ext = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end else begin
                load_ext = rd_word;
            end
        end
    end

    // Single response slot: a new accept overwrites it (the old one is being
    // consumed that same cycle), otherwise it drains when rsp_ready is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_ext;
            rsp_err   <= bad;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu

module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_funct3(req_funct3),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wdata;
    endtask

    // One request with rsp_ready low: valid must appear exactly one edge
    // after the accept edge, then the response is drained.
    task automatic xact(input vec_t v);
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(v.we, v.addr, v.f3, v.wdata);
        chk({v.name, " req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk({v.name, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({v.name, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({v.name, " rsp_err"},   {31'd0, rsp_err}, {31'd0, v.exp_err});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        // Timeout guard in case a sequence stalls.
        #200000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
        $fatal(1, "timeout");
    end

    initial begin
        vt.push_back('{"sw10",   1'b1, 32'h10, 3'b010, 32'h8899AABB, 32'h0, 1'b0});
        vt.push_back('{"lw10",   1'b0, 32'h10, 3'b010, 32'h0, 32'h8899AABB, 1'b0});
        vt.push_back('{"sb13",   1'b1, 32'h13, 3'b000, 32'hFFFFFF5A, 32'h0, 1'b0});
        vt.push_back('{"lw10b",  1'b0, 32'h10, 3'b010, 32'h0, 32'h5A99AABB, 1'b0});
        vt.push_back('{"lb11",   1'b0, 32'h11, 3'b000, 32'h0, 32'hFFFFFFAA, 1'b0});
        vt.push_back('{"lbu11",  1'b0, 32'h11, 3'b100, 32'h0, 32'h000000AA, 1'b0});
        vt.push_back('{"lh12",   1'b0, 32'h12, 3'b001, 32'h0, 32'h00005A99, 1'b0});
        vt.push_back('{"lhu10",  1'b0, 32'h10, 3'b101, 32'h0, 32'h0000AABB, 1'b0});
        vt.push_back('{"lh10",   1'b0, 32'h10, 3'b001, 32'h0, 32'hFFFFAABB, 1'b0});
        vt.push_back('{"sw14",   1'b1, 32'h14, 3'b010, 32'h11223344, 32'h0, 1'b0});
        vt.push_back('{"sh16",   1'b1, 32'h16, 3'b001, 32'h1234BEEF, 32'h0, 1'b0});
        vt.push_back('{"sb14",   1'b1, 32'h14, 3'b000, 32'h00000077, 32'h0, 1'b0});
        vt.push_back('{"lw14",   1'b0, 32'h14, 3'b010, 32'h0, 32'hBEEF3377, 1'b0});
        vt.push_back('{"lb17",   1'b0, 32'h17, 3'b000, 32'h0, 32'hFFFFFFBE, 1'b0});
        vt.push_back('{"sw400",  1'b1, 32'h400, 3'b010, 32'h12345678, 32'h0, 1'b0});
        vt.push_back('{"lw000",  1'b0, 32'h000, 3'b010, 32'h0, 32'h12345678, 1'b0});
        vt.push_back('{"lwhigh", 1'b0, 32'hFFFFF000, 3'b010, 32'h0, 32'h12345678, 1'b0});
        vt.push_back('{"sw20",   1'b1, 32'h20, 3'b010, 32'hA5A5A5A5, 32'h0, 1'b0});
        vt.push_back('{"st011",  1'b1, 32'h20, 3'b011, 32'h00000000, 32'h0, 1'b1});
        vt.push_back('{"st100",  1'b1, 32'h20, 3'b100, 32'h00000000, 32'h0, 1'b1});
        vt.push_back('{"lw20",   1'b0, 32'h20, 3'b010, 32'h0, 32'hA5A5A5A5, 1'b0});
        vt.push_back('{"ld110",  1'b0, 32'h20, 3'b110, 32'h0, 32'h0, 1'b1});
        vt.push_back('{"ld111",  1'b0, 32'h20, 3'b111, 32'h0, 32'h0, 1'b1});
`ifdef DMEM_MISALIGN_TRAP_EN
        vt.push_back('{"lw22",   1'b0, 32'h22, 3'b010, 32'h0, 32'h0, 1'b1});
        vt.push_back('{"lh21",   1'b0, 32'h21, 3'b001, 32'h0, 32'h0, 1'b1});
        vt.push_back('{"sh21",   1'b1, 32'h21, 3'b001, 32'h00000000, 32'h0, 1'b1});
`else
        vt.push_back('{"lw22",   1'b0, 32'h22, 3'b010, 32'h0, 32'hA5A5A5A5, 1'b0});
        vt.push_back('{"lh21",   1'b0, 32'h21, 3'b001, 32'h0, 32'hFFFFA5A5, 1'b0});
        vt.push_back('{"sh21",   1'b1, 32'h21, 3'b001, 32'h00000000, 32'h0, 1'b0});
`endif
        vt.push_back('{"lw20c",  1'b0, 32'h20,
`ifdef DMEM_MISALIGN_TRAP_EN
                       3'b010, 32'h0, 32'hA5A5A5A5, 1'b0});
`else
                       3'b010, 32'h0, 32'hA5A50000, 1'b0});
`endif

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b010;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err",   {31'd0, rsp_err}, 32'd0);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;

        foreach (vt[i]) xact(vt[i]);

        // Backpressure: response held 3 cycles, next request waits, then
        // goes through in the same cycle rsp_ready rises.
        @(negedge clk);
        drive(1'b0, 32'h10, 3'b010, 32'h0);
        @(posedge clk);
        #1 drive(1'b0, 32'h11, 3'b100, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold rsp_rdata", rsp_rdata, 32'h5A99AABB);
        end
        rsp_ready = 1'b1;
        #1 chk("release req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b rsp_rdata", rsp_rdata, 32'h000000AA);
        @(posedge clk);
        @(negedge clk);
        chk("drain rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;

        // Reset while a response is pending discards it.
        drive(1'b0, 32'h14, 3'b010, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("pend rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstpend rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstpend rsp_rdata", rsp_rdata, 32'd0);

        // Store presented during reset must not write nor respond.
        drive(1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rststore rsp_valid", {31'd0, rsp_valid}, 32'd0);
        xact('{"lw10after", 1'b0, 32'h10, 3'b010, 32'h0, 32'h5A99AABB, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
